// File: rtl/pomdp_step_driver_pkg.sv
// Shared types and constants for the POMDP simulation loop: action/probability
// types, the step-driver FSM states and the LFSR feedback taps.
package pomdp_pkg;

    localparam int NUM_ACTIONS = 3;
    localparam int NUM_STATES  = 2;

    typedef logic [1:0]  action_t;
    typedef logic [15:0] prob_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        UPDATE,
        DONE
    } drv_state_e;

    // Polynomial x^16+x^14+x^13+x^11+1 expressed as a mask over bits [15:0].
    localparam prob_t LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/pomdp_step_driver_lfsr16.sv
// 16-bit Fibonacci LFSR: shifts left with the feedback entering at bit 0.
// A load takes priority over an advance.
module lfsr16
    import pomdp_pkg::*;
#(
    parameter prob_t RESET_VAL = 16'hACE1
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load,
    input  prob_t seed,
    input  logic  adv,
    output prob_t q
);

    prob_t lfsr_q;
    prob_t lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = seed;
        end else if (adv) begin
            lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= RESET_VAL;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/pomdp_step_driver.sv
// Episode driver: picks an action per step, requests a transition from the
// environment sampler and accumulates the saturated reward.
module pomdp_step_driver
    import pomdp_pkg::*;
#(
    parameter prob_t LFSR_SEED = 16'hACE1,
    parameter int    ACC_W     = 24
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [15:0]                   num_steps,
    input  logic                          init_state,
    input  logic [1:0][1:0]               policy,
    input  logic signed [2:0][1:0][15:0]  reward,
    output logic                          env_req,
    output action_t                       env_action,
    output logic                          env_state,
    output prob_t                         env_random,
    input  logic                          env_ack,
    input  logic                          env_new_state,
    output logic                          busy,
    output logic                          done,
    output logic [15:0]                   steps_done,
    output logic                          cur_state,
    output logic signed [ACC_W-1:0]       total_reward,
    output logic                          err
);

    localparam prob_t SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    drv_state_e        state_q, state_d;
    logic [15:0]       numSteps_q, numSteps_d;
    logic [15:0]       stepsDone_q, stepsDone_d;
    logic              curState_q, curState_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              err_q, err_d;

    action_t           rawAction;
    action_t           action;
    logic [15:0]       stepReward;
    logic [ACC_W:0]    sumExt;
    logic [ACC_W-1:0]  satSum;
    logic              lfsrLoad;
    logic              lfsrAdv;
    prob_t             lfsrQ;

    lfsr16 #(
        .RESET_VAL(SEED_EFF)
    ) uLfsr (
        .clk  (clk),
        .rst_n(rst_n),
        .load (lfsrLoad),
        .seed (SEED_EFF),
        .adv  (lfsrAdv),
        .q    (lfsrQ)
    );

    // Action 3 does not exist; it is replaced by action 0 and flagged through err.
    always_comb begin
        rawAction  = policy[curState_q];
        action     = (rawAction == 2'd3) ? 2'd0 : rawAction;
        stepReward = reward[action][curState_q];
        sumExt     = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-15){stepReward[15]}}, stepReward};
        if (sumExt[ACC_W] != sumExt[ACC_W-1]) begin
            satSum = sumExt[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            satSum = sumExt[ACC_W-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        numSteps_d  = numSteps_q;
        stepsDone_d = stepsDone_q;
        curState_d  = curState_q;
        acc_d       = acc_q;
        err_d       = err_q;
        lfsrLoad    = 1'b0;
        lfsrAdv     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    numSteps_d  = num_steps;
                    stepsDone_d = '0;
                    curState_d  = init_state;
                    acc_d       = '0;
                    err_d       = 1'b0;
                    lfsrLoad    = 1'b1;
                    state_d     = (num_steps == 16'd0) ? DONE : REQ;
                end
            end
            REQ: begin
                if (rawAction == 2'd3) begin
                    err_d = 1'b1;
                end
                if (env_ack) begin
                    curState_d  = env_new_state;
                    stepsDone_d = stepsDone_q + 16'd1;
                    acc_d       = satSum;
                    lfsrAdv     = 1'b1;
                    state_d     = UPDATE;
                end
            end
            UPDATE: begin
                state_d = (stepsDone_q == numSteps_q) ? DONE : REQ;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            numSteps_q  <= '0;
            stepsDone_q <= '0;
            curState_q  <= 1'b0;
            acc_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            numSteps_q  <= numSteps_d;
            stepsDone_q <= stepsDone_d;
            curState_q  <= curState_d;
            acc_q       <= acc_d;
            err_q       <= err_d;
        end
    end

    assign env_req      = (state_q == REQ);
    assign env_action   = action;
    assign env_state    = curState_q;
    assign env_random   = lfsrQ;
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign steps_done   = stepsDone_q;
    assign cur_state    = curState_q;
    assign total_reward = acc_q;
    assign err          = err_q;

endmodule

// File: tb/tb_pomdp_step_driver.sv
// Self-checking bench for pomdp_step_driver: an episode-level reference model
// compared every cycle, plus directed scenarios with hand-computed results.
module tb_pomdp_step_driver;
    import pomdp_pkg::*;

    localparam int    ACC_W = 24;
    localparam prob_t SEED  = 16'hACE1;
    localparam longint ACC_MAXV = (longint'(1) <<< (ACC_W - 1)) - 1;
    localparam longint ACC_MINV = -(longint'(1) <<< (ACC_W - 1));

    logic                         clk;
    logic                         rst_n;
    logic                         start;
    logic [15:0]                  num_steps;
    logic                         init_state;
    logic [1:0][1:0]              policy;
    logic signed [2:0][1:0][15:0] reward;
    logic                         env_req;
    action_t                      env_action;
    logic                         env_state;
    prob_t                        env_random;
    logic                         env_ack;
    logic                         env_new_state;
    logic                         busy;
    logic                         done;
    logic [15:0]                  steps_done;
    logic                         cur_state;
    logic signed [ACC_W-1:0]      total_reward;
    logic                         err;

    int errors = 0;
    int checks = 0;
    int doneCount = 0;
    int reqCount = 0;
    int ackDelay = 0;
    logic envNext = 1'b0;

    pomdp_step_driver #(
        .LFSR_SEED(SEED),
        .ACC_W    (ACC_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .num_steps    (num_steps),
        .init_state   (init_state),
        .policy       (policy),
        .reward       (reward),
        .env_req      (env_req),
        .env_action   (env_action),
        .env_state    (env_state),
        .env_random   (env_random),
        .env_ack      (env_ack),
        .env_new_state(env_new_state),
        .busy         (busy),
        .done         (done),
        .steps_done   (steps_done),
        .cur_state    (cur_state),
        .total_reward (total_reward),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs as seen by the DUT at the most recent rising edge.
    logic                         cStart = 1'b0;
    logic                         cAck = 1'b0;
    logic                         cNew = 1'b0;
    logic                         cInit = 1'b0;
    logic                         cRst = 1'b0;
    logic [15:0]                  cNum = '0;
    logic [1:0][1:0]              cPolicy = '0;
    logic signed [2:0][1:0][15:0] cReward = '0;

    always @(posedge clk) begin
        cStart  = start;
        cAck    = env_ack;
        cNew    = env_new_state;
        cInit   = init_state;
        cRst    = rst_n;
        cNum    = num_steps;
        cPolicy = policy;
        cReward = reward;
    end

    // Episode-level reference: what the driver owes the environment each cycle.
    bit     mBusy, mReq, mDone, mErr, mCur;
    int     mSteps, mNum;
    longint mAcc;
    prob_t  mLfsr;

    function automatic prob_t lfsrStep(input prob_t v);
        int taps [4] = '{16, 14, 13, 11};
        logic fb = 1'b0;
        foreach (taps[k]) fb = fb ^ v[taps[k] - 1];
        return prob_t'({v[14:0], fb});
    endfunction

    function automatic int legalAction(input logic [1:0] a);
        return (a == 2'd3) ? 0 : int'(a);
    endfunction

    task automatic modelReset();
        mBusy = 0; mReq = 0; mDone = 0; mErr = 0; mCur = 0;
        mSteps = 0; mNum = 0; mAcc = 0; mLfsr = SEED;
    endtask

    task automatic modelCycle();
        int a;
        longint r;
        if (mDone) begin
            mDone = 0;
            mBusy = 0;
        end else if (!mBusy) begin
            if (cStart) begin
                mCur = cInit; mSteps = 0; mAcc = 0; mErr = 0;
                mLfsr = SEED; mNum = int'(cNum); mBusy = 1;
                if (cNum == 16'd0) mDone = 1;
                else mReq = 1;
            end
        end else if (mReq) begin
            if (cPolicy[mCur] == 2'd3) mErr = 1;
            if (cAck) begin
                a = legalAction(cPolicy[mCur]);
                r = longint'($signed(cReward[a][mCur]));
                mAcc = mAcc + r;
                if (mAcc > ACC_MAXV) mAcc = ACC_MAXV;
                if (mAcc < ACC_MINV) mAcc = ACC_MINV;
                mSteps++;
                mCur = cNew;
                mLfsr = lfsrStep(mLfsr);
                mReq = 0;
            end
        end else begin
            if (mSteps == mNum) mDone = 1;
            else mReq = 1;
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n || !cRst) modelReset();
        else modelCycle();
        checkOutput("env_req", env_req, mReq);
        checkOutput("busy", busy, mBusy);
        checkOutput("done", done, mDone);
        checkOutput("steps_done", steps_done, mSteps);
        checkOutput("cur_state", cur_state, mCur);
        checkOutput("env_state", env_state, mCur);
        checkOutput("env_random", env_random, mLfsr);
        checkOutput("total_reward", total_reward, mAcc);
        checkOutput("err", err, mErr);
        if (mReq) checkOutput("env_action", env_action, legalAction(policy[mCur]));
        if (done) doneCount++;
        if (env_req) reqCount++;
    end

    // Environment sampler: acknowledges after ackDelay cycles of waiting.
    int envWait = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            env_ack = 1'b0;
            envWait = 0;
        end else if (env_req && !env_ack) begin
            if (envWait >= ackDelay) begin
                env_ack = 1'b1;
                env_new_state = envNext;
            end else begin
                envWait++;
            end
        end else begin
            env_ack = 1'b0;
            envWait = 0;
        end
    end

    task automatic applyStimulus(input int num, input logic init, input int delay,
                                 input logic nextState, output int cyc);
        @(negedge clk);
        num_steps  = 16'(num);
        init_state = init;
        ackDelay   = delay;
        envNext    = nextState;
        doneCount  = 0;
        reqCount   = 0;
        start      = 1'b1;
        cyc        = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (done) break;
        end
        if (!done) checkOutput("done_timeout", done, 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0;
        start = 1'b0;
        num_steps = '0;
        init_state = 1'b0;
        policy = '0;
        reward = '0;
        reward[0][0] = 16'sd5;
        reward[0][1] = -16'sd3;
        reward[1][0] = 16'sd100;
        reward[1][1] = 16'sd200;
        reward[2][0] = -16'sd50;
        reward[2][1] = 16'sd7;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_env_req", env_req, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_random", env_random, 16'hACE1);

        // Basic episode: +5, then -3 three times.
        applyStimulus(4, 1'b0, 0, 1'b1, cyc);
        checkOutput("basic_cycles", cyc, 9);
        checkOutput("basic_reward", total_reward, -4);
        checkOutput("basic_steps", steps_done, 4);
        checkOutput("basic_state", cur_state, 1);
        checkOutput("basic_done_pulses", doneCount, 1);
        checkOutput("basic_req_cycles", reqCount, 4);

        // Stalled acknowledgement: 5 wait cycles, LFSR steps ACE1->59C3->B387->670F.
        applyStimulus(3, 1'b0, 5, 1'b0, cyc);
        checkOutput("stall_cycles", cyc, 22);
        checkOutput("stall_reward", total_reward, 15);
        checkOutput("stall_random", env_random, 16'h670F);

        // Positive and negative saturation.
        reward[0][0] = 16'h7FFF;
        reward[0][1] = 16'h7FFF;
        applyStimulus(300, 1'b0, 0, 1'b1, cyc);
        checkOutput("sat_pos", total_reward, 8388607);
        reward[0][0] = 16'h8000;
        reward[0][1] = 16'h8000;
        applyStimulus(300, 1'b1, 0, 1'b0, cyc);
        checkOutput("sat_neg", total_reward, -8388608);

        // Zero-length episode.
        applyStimulus(0, 1'b1, 0, 1'b0, cyc);
        checkOutput("zero_cycles", cyc, 1);
        checkOutput("zero_req_cycles", reqCount, 0);
        checkOutput("zero_reward", total_reward, 0);
        checkOutput("zero_state", cur_state, 1);

        // Illegal action in state 0: action 0 used, err sticky until next start.
        reward[0][0] = 16'sd5;
        reward[0][1] = -16'sd3;
        policy[0] = 2'd3;
        policy[1] = 2'd1;
        applyStimulus(3, 1'b0, 0, 1'b0, cyc);
        checkOutput("illegal_err_held", err, 1);
        checkOutput("illegal_reward", total_reward, 15);
        policy[0] = 2'd0;
        applyStimulus(1, 1'b0, 0, 1'b0, cyc);
        checkOutput("illegal_err_cleared", err, 0);

        // Reset during a stalled request, then restart.
        policy[1] = 2'd2;
        @(negedge clk);
        num_steps = 16'd5;
        init_state = 1'b1;
        ackDelay = 5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("pre_reset_req", env_req, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_env_req", env_req, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_state", cur_state, 0);
        checkOutput("rst_steps", steps_done, 0);
        checkOutput("rst_random", env_random, 16'hACE1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        ackDelay = 0;
        envNext = 1'b0;
        @(negedge clk);
        num_steps = 16'd2;
        init_state = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("restart_random0", env_random, 16'hACE1);
        repeat (2) @(negedge clk);
        checkOutput("restart_random1", env_random, 16'h59C3);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done) break;
        end
        checkOutput("restart_done", done, 1);
        repeat (2) @(negedge clk);
        checkOutput("restart_reward", total_reward, 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
